uart_tx_param: RTL
==================

// Module: uart_tx_param
// PURPOSE
//  Parametrised UART transmitter. Serialises one character per valid/ready handshake.
//  Programmable data width, run-time parity (none/even/odd), 1 or 2 stop bits, integer baud divider.
//  Sits between a byte-stream producer (FIFO/CPU regs) and the pad; second generation of our UART TX.
// PARAMETERS
//  DATA_BITS      8    character width, legal 5..9; elaboration error otherwise
//  CLKS_PER_BAUD  868  clocks per bit period (100 MHz / 115200), legal >= 1
//  BAUD_CNT_W     $clog2(CLKS_PER_BAUD+1)  derived localparam, not overridable
// PORTS
//  i_CLK          in   1          single clock, all logic posedge
//  i_RESET_N      in   1          reset: one clock; reset is asynchronous and active-low
//  i_TX_VALID     in   1          producer has a character on i_DATA_IN
//  o_TX_READY     out  1          transmitter can accept; transfer when VALID && READY at posedge
//  i_DATA_IN      in   DATA_BITS  character, sent LSB first
//  i_PARITY_MODE  in   2          00 none, 01 even, 10 odd, 11 reserved (treated as none)
//  i_TWO_STOP     in   1          1 = two stop bits, 0 = one
//  o_TX_BUSY      out  1          high from cycle after acceptance to end of last stop bit
//  o_FRAME_DONE   out  1          one-clock pulse in the final clock of the last stop bit
//  o_TX           out  1          serial line, idle high, driven from a flop (glitch-free)
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, o_TX=1, o_TX_BUSY=0, o_TX_READY=1, o_FRAME_DONE=0,
//   baud counter=0, bit counter=0. Assertion mid-frame aborts immediately; line returns high.
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE.
//  IDLE: o_TX_READY=1. On VALID&&READY capture data, parity mode, stop count into shadow regs;
//   next cycle state=START, o_TX=0. Config inputs are ignored outside acceptance.
//  Each non-IDLE state lasts exactly CLKS_PER_BAUD clocks; baud counter zeroed on entry (phase
//   locked to acceptance, no free-running tick).
//  DATA: bit counter 0..DATA_BITS-1; o_TX = shadow[bit_cnt]; leaves after bit DATA_BITS-1.
//  PARITY: entered only if mode even/odd. Even: bit = ^data. Odd: bit = ~^data.
//  STOP1/STOP2: o_TX=1; STOP2 entered only if two-stop captured.
//  o_TX_READY=0 in every non-IDLE state; VALID while busy is held off, data not sampled.
//  Frame length = CLKS_PER_BAUD*(1+DATA_BITS+P+S) clocks, P in {0,1}, S in {1,2}.
//  After STOP exit, IDLE lasts >= 1 clock; back-to-back frames have exactly 1 idle clock
//   between the last stop bit and the next start bit.
//  CLKS_PER_BAUD=1: every state is a single clock; no counter wrap corner cases allowed.
//  Reserved parity 2'b11 behaves exactly as none.
//  o_TX_BUSY = (state != IDLE); o_FRAME_DONE registered alongside state transition.
// STRUCTURE
//  uart_pkg: state encodings, PARITY_NONE/EVEN/ODD constants, shared with future uart_rx_param.
//  Sub-module uart_baud_gen: loadable down-counter, inputs clr/en, output bit_end pulse when the
//   current bit period completes; parametrised by CLKS_PER_BAUD.
//  Top: FSM, shift/bit counter, parity accumulator, registered o_TX.
// TESTING  (DATA_BITS=8, CLKS_PER_BAUD=4 unless noted)
//  0xA5, even, 1 stop -> line 0,1,0,1,0,0,1,0,1,P=0,1; each bit 4 clk; 44 clk busy; DONE pulses once.
//  0xA5, odd, 2 stop -> same data, P=1, two stop bits; 48 clk busy; READY low throughout.
//  0x3C, none, 1 stop, VALID held high 3 frames -> frames 40 clk each, exactly 1 idle clk between.
//  Reset low during DATA bit 3 -> o_TX=1, BUSY=0, READY=1 same cycle; next frame starts clean.
//  Config change mid-frame (parity none->odd) -> current frame unchanged, next frame uses odd.
//  DATA_BITS=5, CLKS_PER_BAUD=1, 0x1F even -> 0,1,1,1,1,1,P=1,1; 8 clk busy.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and parity-mode constants,
// intended for reuse by both the transmitter and a future receiver.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP1  = 3'd4;
  localparam logic [2:0] ST_STOP2  = 3'd5;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  // Reserved encoding 2'b11 deliberately falls through to "no parity".
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts clocks since the start of the current bit and
// pulses bit_end in the last clock of the period. Cleared while idle.
module uart_baud_gen #(
  parameter  int CLKS_PER_BAUD = 868,
  localparam int BAUD_CNT_W    = $clog2(CLKS_PER_BAUD + 1)
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET_N,
  input  logic                  i_CLR,
  input  logic                  i_EN,
  output logic                  o_BIT_END,
  output logic [BAUD_CNT_W-1:0] o_CNT
);

  localparam logic [BAUD_CNT_W-1:0] LAST = BAUD_CNT_W'(CLKS_PER_BAUD - 1);

  logic [BAUD_CNT_W-1:0] cnt_reg;

  assign o_BIT_END = i_EN && (cnt_reg == LAST);
  assign o_CNT     = cnt_reg;

  // Restarting on bit_end keeps every bit exactly CLKS_PER_BAUD clocks, including CLKS_PER_BAUD=1.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      cnt_reg <= '0;
    end else if (i_CLR || o_BIT_END) begin
      cnt_reg <= '0;
    end else if (i_EN) begin
      cnt_reg <= cnt_reg + BAUD_CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: one character per valid/ready handshake,
// run-time parity and stop-bit selection, registered glitch-free serial output.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter  int DATA_BITS     = 8,
  parameter  int CLKS_PER_BAUD = 868,
  localparam int BAUD_CNT_W    = $clog2(CLKS_PER_BAUD + 1)
) (
  input  logic                 i_CLK,
  input  logic                 i_RESET_N,
  input  logic                 i_TX_VALID,
  output logic                 o_TX_READY,
  input  logic [DATA_BITS-1:0] i_DATA_IN,
  input  logic [1:0]           i_PARITY_MODE,
  input  logic                 i_TWO_STOP,
  output logic                 o_TX_BUSY,
  output logic                 o_FRAME_DONE,
  output logic                 o_TX
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (CLKS_PER_BAUD < 1) begin : gen_bad_clks_per_baud
    $error("uart_tx_param: CLKS_PER_BAUD must be >= 1");
  end

  localparam int                    BIT_CNT_W = $clog2(DATA_BITS);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BAUD_CNT_W-1:0] PRE_LAST  =
    BAUD_CNT_W'((CLKS_PER_BAUD >= 2) ? (CLKS_PER_BAUD - 2) : 0);

  logic [2:0]            state_reg, state_next;
  logic                  tx_reg, tx_next;
  logic                  done_reg, done_next;
  logic [DATA_BITS-1:0]  shift_reg, shift_next;
  logic [BIT_CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic                  par_en_reg, par_en_next;
  logic                  par_bit_reg, par_bit_next;
  logic                  two_stop_reg, two_stop_next;
  logic                  last_stop_next;
  logic                  bit_end;
  logic [BAUD_CNT_W-1:0] baud_cnt;

  uart_baud_gen #(.CLKS_PER_BAUD(CLKS_PER_BAUD)) u_baud (
    .i_CLK     (i_CLK),
    .i_RESET_N (i_RESET_N),
    .i_CLR     (state_reg == ST_IDLE),
    .i_EN      (state_reg != ST_IDLE),
    .o_BIT_END (bit_end),
    .o_CNT     (baud_cnt)
  );

  // tx_next always carries the line level of the state being entered, so o_TX stays a plain flop.
  always_comb begin
    state_next    = state_reg;
    tx_next       = tx_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    par_en_next   = par_en_reg;
    par_bit_next  = par_bit_reg;
    two_stop_next = two_stop_reg;
    case (state_reg)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (i_TX_VALID) begin
          state_next    = ST_START;
          tx_next       = 1'b0;
          shift_next    = i_DATA_IN;
          bit_cnt_next  = '0;
          par_en_next   = parity_enabled(i_PARITY_MODE);
          par_bit_next  = (^i_DATA_IN) ^ (i_PARITY_MODE == PARITY_ODD);
          two_stop_next = i_TWO_STOP;
        end
      end
      ST_START: if (bit_end) begin
        state_next = ST_DATA;
        tx_next    = shift_reg[0];
      end
      ST_DATA: if (bit_end) begin
        if (bit_cnt_reg == LAST_BIT) begin
          state_next = par_en_reg ? ST_PARITY : ST_STOP1;
          tx_next    = par_en_reg ? par_bit_reg : 1'b1;
        end else begin
          bit_cnt_next = bit_cnt_reg + BIT_CNT_W'(1);
          shift_next   = shift_reg >> 1;
          tx_next      = shift_reg[1];
        end
      end
      ST_PARITY: if (bit_end) begin
        state_next = ST_STOP1;
        tx_next    = 1'b1;
      end
      ST_STOP1: if (bit_end) begin
        state_next = two_stop_reg ? ST_STOP2 : ST_IDLE;
        tx_next    = 1'b1;
      end
      ST_STOP2: if (bit_end) begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
      end
    endcase
    // Done is raised for the final clock of the last stop bit: on entry when a bit is one clock long.
    last_stop_next = (state_next == ST_STOP2) || ((state_next == ST_STOP1) && !two_stop_reg);
    done_next      = last_stop_next &&
                     (bit_end ? (CLKS_PER_BAUD == 1) : (baud_cnt == PRE_LAST));
  end

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_reg    <= ST_IDLE;
      tx_reg       <= 1'b1;
      done_reg     <= 1'b0;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
      two_stop_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tx_reg       <= tx_next;
      done_reg     <= done_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      par_en_reg   <= par_en_next;
      par_bit_reg  <= par_bit_next;
      two_stop_reg <= two_stop_next;
    end
  end

  assign o_TX         = tx_reg;
  assign o_TX_BUSY    = (state_reg != ST_IDLE);
  assign o_TX_READY   = (state_reg == ST_IDLE);
  assign o_FRAME_DONE = done_reg;

endmodule
